// File: rtl/cont_bcd_mod_n.sv
// Multi-digit modulo-N up/down counter with parallel load, terminal count and wrap pulse.
// Each digit is a 4-bit field; digit 0 sits in the low nibble.
module cont_bcd_mod_n #(
  parameter int DIGITS = 2,
  parameter int MODULO = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err
);

  localparam logic [3:0] DMAX = 4'(MODULO - 1);
  localparam logic [4:0] DMOD = 5'(MODULO);

  logic [4*DIGITS-1:0] q_r;
  logic [4*DIGITS-1:0] q_next;
  logic [4*DIGITS-1:0] ld_q;
  logic [DIGITS-1:0]   step_up;
  logic [DIGITS-1:0]   step_dn;
  logic [DIGITS-1:0]   ld_bad;
  logic                run_max;
  logic                run_zero;
  logic                all_max;
  logic                all_zero;
  logic                wrap_r;
  logic                load_err_r;

  // Ripple carry/borrow: a digit steps when every lower digit sits at its rollover value.
  always_comb begin
    run_max  = 1'b1;
    run_zero = 1'b1;
    step_up  = '0;
    step_dn  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      step_up[i] = run_max;
      step_dn[i] = run_zero;
      run_max    = run_max  & (q_r[4*i +: 4] == DMAX);
      run_zero   = run_zero & (q_r[4*i +: 4] == 4'd0);
    end
    all_max  = run_max;
    all_zero = run_zero;
  end

  // Out-of-range digits are treated as just past the top: up goes to 0, down goes to MODULO-1.
  always_comb begin
    q_next = q_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (en) begin
        if (up && step_up[i]) begin
          q_next[4*i +: 4] = (q_r[4*i +: 4] >= DMAX) ? 4'd0 : q_r[4*i +: 4] + 4'd1;
        end else if (!up && step_dn[i]) begin
          q_next[4*i +: 4] = ((q_r[4*i +: 4] == 4'd0) || (q_r[4*i +: 4] > DMAX)) ?
                             DMAX : q_r[4*i +: 4] - 4'd1;
        end
      end
    end
  end

  always_comb begin
    ld_q   = '0;
    ld_bad = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if ({1'b0, load_val[4*i +: 4]} < DMOD) begin
        ld_q[4*i +: 4] = load_val[4*i +: 4];
      end else begin
        ld_bad[i] = 1'b1;
      end
    end
  end

  assign tc = en & ~load & (up ? all_max : all_zero);

  // tc already excludes load, so it doubles as the wrap-about-to-happen condition.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r        <= '0;
      wrap_r     <= 1'b0;
      load_err_r <= 1'b0;
    end else if (load) begin
      q_r        <= ld_q;
      wrap_r     <= 1'b0;
      load_err_r <= |ld_bad;
    end else begin
      q_r        <= q_next;
      wrap_r     <= tc;
    end
  end

  assign q        = q_r;
  assign wrap     = wrap_r;
  assign load_err = load_err_r;

endmodule

// File: tb/tb_cont_bcd_mod_n.sv
// Bench for cont_bcd_mod_n: a 2-digit decade instance and a 1-digit mod-6 instance,
// compared every cycle against an integer-value model, plus directed literal checks.
module tb_cont_bcd_mod_n;

  logic       clk;
  logic       rst_a, en_a, up_a, load_a;
  logic [7:0] lv_a, q_a;
  logic       tc_a, wrap_a, err_a;
  logic       rst_b, en_b, up_b, load_b;
  logic [3:0] lv_b, q_b;
  logic       tc_b, wrap_b, err_b;

  int  n_pass  = 0;
  int  n_total = 0;
  bit  chk_on  = 0;

  int  va, vb;
  bit  wa, wb, ea, eb;

  cont_bcd_mod_n #(.DIGITS(2), .MODULO(10)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .up(up_a), .load(load_a),
    .load_val(lv_a), .q(q_a), .tc(tc_a), .wrap(wrap_a), .load_err(err_a));

  cont_bcd_mod_n #(.DIGITS(1), .MODULO(6)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .up(up_b), .load(load_b),
    .load_val(lv_b), .q(q_b), .tc(tc_b), .wrap(wrap_b), .load_err(err_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int total_states(int m, int d);
    int t = 1;
    for (int i = 0; i < d; i++) t = t * m;
    return t;
  endfunction

  // Integer count value -> packed 4-bit digits.
  function automatic logic [31:0] enc(int v, int m, int d);
    logic [31:0] r = '0;
    int          x = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % m);
      x = x / m;
    end
    return r;
  endfunction

  task automatic model_step(input bit r, input bit l, input bit e, input bit u,
                            input logic [31:0] lv, input int m, input int d,
                            input int v_in, input bit e_in,
                            output int v_out, output bit w_out, output bit e_out);
    int tot  = total_states(m, d);
    int mult = 1;
    v_out = v_in;
    w_out = 1'b0;
    e_out = e_in;
    if (r) begin
      v_out = 0;
      e_out = 1'b0;
    end else if (l) begin
      v_out = 0;
      e_out = 1'b0;
      for (int i = 0; i < d; i++) begin
        if (int'(lv[4*i +: 4]) >= m) e_out = 1'b1;
        else v_out = v_out + int'(lv[4*i +: 4]) * mult;
        mult = mult * m;
      end
    end else if (e) begin
      w_out = u ? (v_in == tot - 1) : (v_in == 0);
      v_out = u ? (v_in + 1) % tot : (v_in + tot - 1) % tot;
    end
  endtask

  function automatic bit exp_tc(bit e, bit l, bit u, int v, int m, int d);
    return e && !l && (u ? (v == total_states(m, d) - 1) : (v == 0));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    model_step(rst_a, load_a, en_a, up_a, {24'b0, lv_a}, 10, 2, va, ea, va, wa, ea);
    model_step(rst_b, load_b, en_b, up_b, {28'b0, lv_b}, 6, 1, vb, eb, vb, wb, eb);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_q_a",    {24'b0, q_a}, enc(va, 10, 2));
      check("model_tc_a",   {31'b0, tc_a}, {31'b0, exp_tc(en_a, load_a, up_a, va, 10, 2)});
      check("model_wrap_a", {31'b0, wrap_a}, {31'b0, wa});
      check("model_err_a",  {31'b0, err_a}, {31'b0, ea});
      check("model_q_b",    {28'b0, q_b}, enc(vb, 6, 1));
      check("model_tc_b",   {31'b0, tc_b}, {31'b0, exp_tc(en_b, load_b, up_b, vb, 6, 1)});
      check("model_wrap_b", {31'b0, wrap_b}, {31'b0, wb});
      check("model_err_b",  {31'b0, err_b}, {31'b0, eb});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] seq_up [9] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1, 4'd2, 4'd3};
  logic [3:0] seq_dn [4] = '{4'd2, 4'd1, 4'd0, 4'd5};

  initial begin
    rst_a = 1; en_a = 0; up_a = 0; load_a = 0; lv_a = '0;
    rst_b = 1; en_b = 0; up_b = 0; load_b = 0; lv_b = '0;
    step();
    chk_on = 1;
    check("reset_q_a", {24'b0, q_a}, 32'h00);
    check("reset_err_a", {31'b0, err_a}, 32'h0);

    // Count 00..99 then wrap.
    rst_a = 0; en_a = 1; up_a = 1;
    repeat (99) step();
    check("up_q99", {24'b0, q_a}, 32'h99);
    check("up_tc99", {31'b0, tc_a}, 32'h1);
    step();
    check("up_wrap_q", {24'b0, q_a}, 32'h00);
    check("up_wrap_pulse", {31'b0, wrap_a}, 32'h1);
    step();
    check("up_after_q", {24'b0, q_a}, 32'h01);
    check("up_wrap_gone", {31'b0, wrap_a}, 32'h0);

    // Down from 00.
    en_a = 0; load_a = 1; lv_a = 8'h00;
    step();
    load_a = 0; up_a = 0; en_a = 1;
    #1;
    check("dn_tc00", {31'b0, tc_a}, 32'h1);
    step();
    check("dn_q99", {24'b0, q_a}, 32'h99);
    check("dn_wrap", {31'b0, wrap_a}, 32'h1);

    // Illegal and legal loads.
    en_a = 0; load_a = 1; lv_a = 8'h3C;
    step();
    check("ld_bad_q", {24'b0, q_a}, 32'h30);
    check("ld_bad_err", {31'b0, err_a}, 32'h1);
    check("ld_bad_wrap", {31'b0, wrap_a}, 32'h0);
    lv_a = 8'h42;
    step();
    check("ld_ok_q", {24'b0, q_a}, 32'h42);
    check("ld_ok_err", {31'b0, err_a}, 32'h0);

    // Hold, then load beats enable.
    lv_a = 8'h19;
    step();
    load_a = 0;
    repeat (5) step();
    check("hold_q", {24'b0, q_a}, 32'h19);
    check("hold_tc", {31'b0, tc_a}, 32'h0);
    en_a = 1; up_a = 1; load_a = 1; lv_a = 8'h55;
    step();
    check("ld_wins_q", {24'b0, q_a}, 32'h55);

    // Reset beats load and count.
    lv_a = 8'hFF; rst_a = 1;
    step();
    check("rst_wins_q", {24'b0, q_a}, 32'h00);
    check("rst_wins_wrap", {31'b0, wrap_a}, 32'h0);
    check("rst_wins_err", {31'b0, err_a}, 32'h0);
    rst_a = 0; load_a = 0; en_a = 0;

    // Mod-6 single digit with direction change at 3.
    rst_b = 0; en_b = 1; up_b = 1;
    for (int i = 0; i < 9; i++) begin
      step();
      check("m6_up_q", {28'b0, q_b}, {28'b0, seq_up[i]});
      if (i == 5) check("m6_up_wrap", {31'b0, wrap_b}, 32'h1);
    end
    up_b = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("m6_dn_q", {28'b0, q_b}, {28'b0, seq_dn[i]});
      if (i == 3) check("m6_dn_wrap", {31'b0, wrap_b}, 32'h1);
    end

    // Randomized traffic on both instances.
    for (int c = 0; c < 2000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      rst_a  = (r < 2);
      load_a = (r >= 2 && r < 8);
      en_a   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) up_a = ~up_a;
      lv_a   = 8'($urandom);
      r = $urandom_range(0, 99);
      rst_b  = (r < 2);
      load_b = (r >= 2 && r < 10);
      en_b   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) up_b = ~up_b;
      lv_b   = 4'($urandom);
      step();
    end

    rst_a = 0; load_a = 0; en_a = 0;
    rst_b = 0; load_b = 0; en_b = 0;
    step();
    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
